// File: rtl/fpu_cluster_ret_merge.sv
// fpu_cluster_ret_merge: retire/exception collector for an N-lane FPU cluster.
// Per-lane staging registers feed a round-robin arbiter that writes one record
// per cycle into an in-order merge FIFO. The FIFO head is presented to the
// retire unit. Sticky exception status, a protocol-error flag and a trap
// indication for unmasked exceptions are maintained alongside.
//
// Optional build macro FPU_RET_STAT_EN adds stat_cnt: per-lane saturating
// counters of granted records that carry nonzero raise flags.
//
// Handshakes: a lane record transfers on a cycle where lane_ret_en[i] and
// lane_rdy[i] are both high; the head record transfers on a cycle where
// out_valid and out_ready are both high. lane_rdy does not depend on
// lane_ret_en. A record offered while lane_rdy is low is dropped and flagged.
module fpu_cluster_ret_merge #(
    parameter int LANES  = 3,
    parameter int RET_W  = 14,
    parameter int FLAG_W = 11,
    parameter int DEPTH  = 8,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*RET_W-1:0]  lane_ret,
    input  logic [LANES*FLAG_W-1:0] lane_raise,
    input  logic [LANES-1:0]        lane_ret_en,
    output logic [LANES-1:0]        lane_rdy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RET_W-1:0]        out_ret,
    output logic [FLAG_W-1:0]       out_raise,
    output logic [LW-1:0]           out_lane,
    output logic                    out_trap,
    input  logic [FLAG_W-1:0]       trap_en,
    output logic [FLAG_W-1:0]       sticky,
    input  logic                    sticky_clr,
`ifdef FPU_RET_STAT_EN
    output logic [LANES*16-1:0]     stat_cnt,
`endif
    output logic                    proto_err
);

    localparam int PW = $clog2(DEPTH);

    logic [LANES-1:0]  stage_full;
    logic [RET_W-1:0]  stage_ret   [LANES];
    logic [FLAG_W-1:0] stage_raise [LANES];
    logic [LW-1:0]     rr;

    logic [LANES-1:0]  grant;
    logic              grant_any;
    logic [LW-1:0]     grant_idx;
    logic [RET_W-1:0]  grant_ret;
    logic [FLAG_W-1:0] grant_raise;
    logic [LANES-1:0]  capture;
    logic              violation;

    logic [RET_W-1:0]  mem_ret   [DEPTH];
    logic [FLAG_W-1:0] mem_raise [DEPTH];
    logic [LW-1:0]     mem_lane  [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              fifo_full;
    logic              pop;
    logic              can_grant;

    assign out_valid = (count != '0);
    assign fifo_full = (count == (PW+1)'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A full FIFO can still accept a write when the head leaves this cycle.
    assign can_grant = ~fifo_full | pop;

    // Round-robin search for the first full stage starting at rr.
    always_comb begin
        int idx;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < LANES; k++) begin
            idx = int'(rr) + k;
            if (idx >= LANES) idx = idx - LANES;
            if (!grant_any && can_grant && stage_full[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = LW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign grant_ret   = stage_ret[grant_idx];
    assign grant_raise = stage_raise[grant_idx];
    assign lane_rdy    = ~stage_full | grant;
    assign capture     = lane_ret_en & lane_rdy;
    assign violation   = |(lane_ret_en & ~lane_rdy);

    // Per-lane staging: load on capture, free on grant (capture wins so a
    // lane can stream one record per cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_full <= '0;
            for (int i = 0; i < LANES; i++) begin
                stage_ret[i]   <= '0;
                stage_raise[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (capture[i]) begin
                    stage_full[i]  <= 1'b1;
                    stage_ret[i]   <= lane_ret[i*RET_W +: RET_W];
                    stage_raise[i] <= lane_raise[i*FLAG_W +: FLAG_W];
                end else if (grant[i]) begin
                    stage_full[i]  <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves past the granted lane; holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= '0;
        end else if (grant_any) begin
            rr <= (grant_idx == LW'(LANES - 1)) ? '0 : LW'(grant_idx + 1'b1);
        end
    end

    // FIFO pointers and occupancy; the extra count bit separates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant_any) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({grant_any, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            mem_ret[wr_ptr]   <= grant_ret;
            mem_raise[wr_ptr] <= grant_raise;
            mem_lane[wr_ptr]  <= grant_idx;
        end
    end

    assign out_ret   = out_valid ? mem_ret[rd_ptr]   : '0;
    assign out_raise = out_valid ? mem_raise[rd_ptr] : '0;
    assign out_lane  = out_valid ? mem_lane[rd_ptr]  : '0;
    assign out_trap  = out_valid & (|(out_raise & trap_en));

    // Sticky status and protocol error: a same-cycle set survives a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky    <= '0;
            proto_err <= 1'b0;
        end else begin
            sticky    <= (sticky_clr ? '0 : sticky) | (grant_any ? grant_raise : '0);
            proto_err <= (sticky_clr ? 1'b0 : proto_err) | violation;
        end
    end

`ifdef FPU_RET_STAT_EN
    logic [15:0] stat_q [LANES];

    // Per-lane count of granted records with raised flags; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (sticky_clr) begin
                    stat_q[i] <= '0;
                end else if (grant[i] && (grant_raise != '0) && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < LANES; i++) stat_cnt[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fpu_cluster_ret_merge.sv
// Self-checking bench for fpu_cluster_ret_merge (default parameters).
module tb_fpu_cluster_ret_merge;

    localparam int LANES  = 3;
    localparam int RET_W  = 14;
    localparam int FLAG_W = 11;
    localparam int DEPTH  = 8;
    localparam int LW     = 2;
    localparam int W      = LW + RET_W + FLAG_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [LANES*RET_W-1:0]  lane_ret;
    logic [LANES*FLAG_W-1:0] lane_raise;
    logic [LANES-1:0]        lane_ret_en;
    logic [LANES-1:0]        lane_rdy;
    logic                    out_valid;
    logic                    out_ready;
    logic [RET_W-1:0]        out_ret;
    logic [FLAG_W-1:0]       out_raise;
    logic [LW-1:0]           out_lane;
    logic                    out_trap;
    logic [FLAG_W-1:0]       trap_en;
    logic [FLAG_W-1:0]       sticky;
    logic                    sticky_clr;
    logic                    proto_err;
`ifdef FPU_RET_STAT_EN
    logic [LANES*16-1:0]     stat_cnt;
`endif

    logic [W-1:0]      exp_q[$];
    logic [FLAG_W-1:0] exp_sticky;
    int                n_tests = 0;
    int                n_fail  = 0;

    fpu_cluster_ret_merge #(
        .LANES(LANES), .RET_W(RET_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .lane_ret(lane_ret), .lane_raise(lane_raise), .lane_ret_en(lane_ret_en),
        .lane_rdy(lane_rdy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ret(out_ret), .out_raise(out_raise), .out_lane(out_lane),
        .out_trap(out_trap), .trap_en(trap_en),
        .sticky(sticky), .sticky_clr(sticky_clr),
`ifdef FPU_RET_STAT_EN
        .stat_cnt(stat_cnt),
`endif
        .proto_err(proto_err)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Compare helper
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        lane_ret_en = '0;
        sticky_clr  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_sticky = '0;
    endtask

    task automatic push_exp(input logic [LW-1:0] lane, input logic [RET_W-1:0] r,
                            input logic [FLAG_W-1:0] f);
        exp_q.push_back({lane, r, f});
        exp_sticky = exp_sticky | f;
    endtask

    // Offer records on the masked lanes for one cycle.
    task automatic offer(input logic [2:0] mask,
                         input logic [RET_W-1:0] r0, input logic [RET_W-1:0] r1,
                         input logic [RET_W-1:0] r2,
                         input logic [FLAG_W-1:0] f0, input logic [FLAG_W-1:0] f1,
                         input logic [FLAG_W-1:0] f2);
        lane_ret    = {r2, r1, r0};
        lane_raise  = {f2, f1, f0};
        lane_ret_en = mask;
        @(posedge clk);
        #1 lane_ret_en = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
    endtask

    // Scoreboard monitor: pops and compares every accepted head record.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL head_unexpected: got lane %0d ret 0x%0h raise 0x%0h, expected none",
                         out_lane, out_ret, out_raise);
            end else begin
                e = exp_q.pop_front();
                if ({out_lane, out_ret, out_raise} !== e) begin
                    n_fail++;
                    $display("FAIL head_record: got lane %0d ret 0x%0h raise 0x%0h expected lane %0d ret 0x%0h raise 0x%0h",
                             out_lane, out_ret, out_raise,
                             e[W-1 -: LW], e[FLAG_W +: RET_W], e[FLAG_W-1:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        lane_ret    = '0;
        lane_raise  = '0;
        lane_ret_en = '0;
        out_ready   = 1'b1;
        trap_en     = '0;
        sticky_clr  = 1'b0;
        exp_sticky  = '0;
        do_reset();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_lane_rdy",  {29'd0, lane_rdy},  32'd7);
        chk("rst_out_ret",   {18'd0, out_ret},   32'd0);
        chk("rst_out_raise", {21'd0, out_raise}, 32'd0);
        chk("rst_out_lane",  {30'd0, out_lane},  32'd0);
        chk("rst_out_trap",  {31'd0, out_trap},  32'd0);
        chk("rst_sticky",    {21'd0, sticky},    32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);

        // Single record on lane 1: presented two cycles after the offer
        push_exp(2'd1, 14'h0123, 11'h004);
        offer(3'b010, 14'h0, 14'h0123, 14'h0, 11'h0, 11'h004, 11'h0);
        @(negedge clk);
        chk("single_early_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("single_valid",  {31'd0, out_valid}, 32'd1);
        chk("single_lane",   {30'd0, out_lane},  32'd1);
        chk("single_sticky", {21'd0, sticky},    32'h004);
        @(posedge clk);
        #1;
        wait_drain("single_drain");

        // Contention from rr=0: order 0,1,2 twice
        do_reset();
        push_exp(2'd0, 14'h00A1, 11'h001);
        push_exp(2'd1, 14'h00A2, 11'h002);
        push_exp(2'd2, 14'h00A3, 11'h020);
        offer(3'b111, 14'h00A1, 14'h00A2, 14'h00A3, 11'h001, 11'h002, 11'h020);
        wait_drain("burst1_drain");
        chk("burst1_sticky", {21'd0, sticky}, 32'h023);
        push_exp(2'd0, 14'h00B1, 11'h000);
        push_exp(2'd1, 14'h00B2, 11'h000);
        push_exp(2'd2, 14'h00B3, 11'h000);
        offer(3'b111, 14'h00B1, 14'h00B2, 14'h00B3, 11'h0, 11'h0, 11'h0);
        wait_drain("burst2_drain");

        // Backpressure: 8 records fill the FIFO, the 9th sits in stage 0
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            push_exp(2'd0, 14'(14'h0200 + k), 11'h000);
            lane_ret[0 +: RET_W]    = 14'(14'h0200 + k);
            lane_raise[0 +: FLAG_W] = '0;
            lane_ret_en = 3'b001;
            chk("bp_lane_rdy", {31'd0, lane_rdy[0]}, 32'd1);
            @(posedge clk);
            #1;
        end
        lane_ret_en = '0;
        @(negedge clk);
        chk("bp_full_rdy", {31'd0, lane_rdy[0]}, 32'd0);
        chk("bp_proto_before", {31'd0, proto_err}, 32'd0);
        @(posedge clk);
        #1;
        lane_ret[0 +: RET_W] = 14'h3FFF;
        lane_ret_en = 3'b001;
        @(posedge clk);
        #1 lane_ret_en = '0;
        chk("bp_proto_err", {31'd0, proto_err}, 32'd1);
        chk("bp_head_lane", {30'd0, out_lane}, 32'd0);
        chk("bp_head_ret",  {18'd0, out_ret},  32'h0200);
        out_ready = 1'b1;
        wait_drain("bp_drain");

        // Trap indication from the head record
        out_ready = 1'b0;
        trap_en   = 11'h010;
        push_exp(2'd2, 14'h0333, 11'h011);
        offer(3'b100, 14'h0, 14'h0, 14'h0333, 11'h0, 11'h0, 11'h011);
        @(negedge clk);
        @(negedge clk);
        chk("trap_valid", {31'd0, out_valid}, 32'd1);
        chk("trap_on",    {31'd0, out_trap},  32'd1);
        chk("trap_raise", {21'd0, out_raise}, 32'h011);
        #1 trap_en = 11'h000;
        #1 chk("trap_masked", {31'd0, out_trap}, 32'd0);
        trap_en = 11'h7FF;
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("trap_drain");
        chk("trap_empty", {31'd0, out_trap}, 32'd0);
        trap_en = 11'h000;
        chk("trap_sticky", {21'd0, sticky}, {21'd0, exp_sticky});

        // Clear versus same-cycle set
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        exp_sticky = '0;
        chk("clr_sticky",    {21'd0, sticky},    32'd0);
        chk("clr_proto_err", {31'd0, proto_err}, 32'd0);
        push_exp(2'd0, 14'h0444, 11'h0FF);
        offer(3'b001, 14'h0444, 14'h0, 14'h0, 11'h0FF, 11'h0, 11'h0);
        wait_drain("pre_clr_drain");
        chk("pre_clr_sticky", {21'd0, sticky}, 32'h0FF);
        push_exp(2'd1, 14'h0555, 11'h100);
        offer(3'b010, 14'h0, 14'h0555, 14'h0, 11'h0, 11'h100, 11'h0);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        chk("clr_vs_set_sticky", {21'd0, sticky}, 32'h100);
        wait_drain("clr_drain");

        // Asynchronous reset with 5 records held in the FIFO
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lane_ret[0 +: RET_W]    = 14'(14'h0600 + k);
            lane_raise[0 +: FLAG_W] = 11'h001;
            lane_ret_en = 3'b001;
            @(posedge clk);
            #1;
        end
        lane_ret_en = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_valid_before",  {31'd0, out_valid}, 32'd1);
        chk("midrst_sticky_before", {21'd0, sticky},    32'h101);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_lane_rdy",  {29'd0, lane_rdy},  32'd7);
        chk("midrst_sticky",    {21'd0, sticky},    32'd0);
        exp_q.delete();
        exp_sticky = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_empty", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
